// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//
// ID/EX pipeline register and execute-stage operand front end for the RV32I pipeline.
// It captures decode-stage operands and control into E and resolves forwarding from M and W.
// It then applies the ALUSrc muxes to produce the ALU operands.
// It also detects load-use hazards: fetch and decode are stalled, and a bubble enters E.
//
// Ports
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   RD1D, RD2D             : register-file read data from decode
//   PCD, ImmExtD           : decode PC and extended immediate
//   Rs1D, Rs2D, RdD        : decode register indices
//   ALUControlD            : ALU operation code
//   ALUSrcAD, ALUSrcBD     : operand selects (1: PC / immediate, 0: forwarded register)
//   RegWriteD, MemWriteD,
//   BranchD, JumpD         : decode control
//   ResultSrcD             : 00 ALU, 01 load, 10 PC+4
//   FlushE                 : squash the instruction entering E
//   ALUResultM, ResultW    : forwarding data from M and W
//   RdM, RdW               : destination indices in M and W
//   RegWriteM, RegWriteW   : write enables in M and W
//   SrcAE, SrcBE           : ALU operands
//   ALUControlE            : registered ALU op
//   WriteDataE             : forwarded rs2 (store data)
//   PCE, ImmExtE           : registered PC and immediate
//   RdE                    : registered destination
//   RegWriteE, MemWriteE,
//   BranchE, JumpE         : registered control
//   ResultSrcE             : registered result select
//   StallF, StallD         : hold PC and IF/ID register

module ex_operand_stage #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned R_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  // Decode stage
  input  logic [D_WIDTH-1:0] RD1D,
  input  logic [D_WIDTH-1:0] RD2D,
  input  logic [D_WIDTH-1:0] PCD,
  input  logic [D_WIDTH-1:0] ImmExtD,
  input  logic [R_WIDTH-1:0] Rs1D,
  input  logic [R_WIDTH-1:0] Rs2D,
  input  logic [R_WIDTH-1:0] RdD,
  input  logic [3:0]         ALUControlD,
  input  logic               ALUSrcAD,
  input  logic               ALUSrcBD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               BranchD,
  input  logic               JumpD,
  input  logic [1:0]         ResultSrcD,
  input  logic               FlushE,
  // Forwarding sources
  input  logic [D_WIDTH-1:0] ALUResultM,
  input  logic [D_WIDTH-1:0] ResultW,
  input  logic [R_WIDTH-1:0] RdM,
  input  logic [R_WIDTH-1:0] RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  // Execute stage
  output logic [D_WIDTH-1:0] SrcAE,
  output logic [D_WIDTH-1:0] SrcBE,
  output logic [3:0]         ALUControlE,
  output logic [D_WIDTH-1:0] WriteDataE,
  output logic [D_WIDTH-1:0] PCE,
  output logic [D_WIDTH-1:0] ImmExtE,
  output logic [R_WIDTH-1:0] RdE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               BranchE,
  output logic               JumpE,
  output logic [1:0]         ResultSrcE,
  // Hazard control
  output logic               StallF,
  output logic               StallD
);

  localparam logic [1:0] ResultLoad = 2'b01;

  // E-stage registers
  logic [D_WIDTH-1:0] r_rd1e;
  logic [D_WIDTH-1:0] r_rd2e;
  logic [D_WIDTH-1:0] r_pce;
  logic [D_WIDTH-1:0] r_immexte;
  logic [R_WIDTH-1:0] r_rs1e;
  logic [R_WIDTH-1:0] r_rs2e;
  logic [R_WIDTH-1:0] r_rde;
  logic [3:0]         r_alucontrole;
  logic               r_alusrcae;
  logic               r_alusrcbe;
  logic               r_regwritee;
  logic               r_memwritee;
  logic               r_branche;
  logic               r_jumpe;
  logic [1:0]         r_resultsrce;

  logic               w_load_use;
  logic               w_bubble;
  logic [D_WIDTH-1:0] w_fwd_a;
  logic [D_WIDTH-1:0] w_fwd_b;

  // A load in E whose destination a decode source still needs. The data only exists after
  // the memory stage, so the consumer waits one cycle and then picks it up through W.
  assign w_load_use = (r_resultsrce == ResultLoad) && r_regwritee && (r_rde != '0) &&
                      ((r_rde == Rs1D) || (r_rde == Rs2D));

  assign w_bubble = FlushE || w_load_use;

  // The bubble zeroes every field, including Rs1E/Rs2E. No write enables are set, and
  // register index 0 is never forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1e        <= '0;
      r_rd2e        <= '0;
      r_pce         <= '0;
      r_immexte     <= '0;
      r_rs1e        <= '0;
      r_rs2e        <= '0;
      r_rde         <= '0;
      r_alucontrole <= '0;
      r_alusrcae    <= 1'b0;
      r_alusrcbe    <= 1'b0;
      r_regwritee   <= 1'b0;
      r_memwritee   <= 1'b0;
      r_branche     <= 1'b0;
      r_jumpe       <= 1'b0;
      r_resultsrce  <= '0;
    end else if (w_bubble) begin
      r_rd1e        <= '0;
      r_rd2e        <= '0;
      r_pce         <= '0;
      r_immexte     <= '0;
      r_rs1e        <= '0;
      r_rs2e        <= '0;
      r_rde         <= '0;
      r_alucontrole <= '0;
      r_alusrcae    <= 1'b0;
      r_alusrcbe    <= 1'b0;
      r_regwritee   <= 1'b0;
      r_memwritee   <= 1'b0;
      r_branche     <= 1'b0;
      r_jumpe       <= 1'b0;
      r_resultsrce  <= '0;
    end else begin
      r_rd1e        <= RD1D;
      r_rd2e        <= RD2D;
      r_pce         <= PCD;
      r_immexte     <= ImmExtD;
      r_rs1e        <= Rs1D;
      r_rs2e        <= Rs2D;
      r_rde         <= RdD;
      r_alucontrole <= ALUControlD;
      r_alusrcae    <= ALUSrcAD;
      r_alusrcbe    <= ALUSrcBD;
      r_regwritee   <= RegWriteD;
      r_memwritee   <= MemWriteD;
      r_branche     <= BranchD;
      r_jumpe       <= JumpD;
      r_resultsrce  <= ResultSrcD;
    end
  end

  // Forwarding: M is younger than W, so it wins when both target the same register.
  always_comb begin
    w_fwd_a = r_rd1e;
    if (RegWriteM && (RdM != '0) && (RdM == r_rs1e)) begin
      w_fwd_a = ALUResultM;
    end else if (RegWriteW && (RdW != '0) && (RdW == r_rs1e)) begin
      w_fwd_a = ResultW;
    end
  end

  always_comb begin
    w_fwd_b = r_rd2e;
    if (RegWriteM && (RdM != '0) && (RdM == r_rs2e)) begin
      w_fwd_b = ALUResultM;
    end else if (RegWriteW && (RdW != '0) && (RdW == r_rs2e)) begin
      w_fwd_b = ResultW;
    end
  end

  assign SrcAE       = r_alusrcae ? r_pce : w_fwd_a;
  assign SrcBE       = r_alusrcbe ? r_immexte : w_fwd_b;
  // Stores take rs2 even when SrcB carries the address offset.
  assign WriteDataE  = w_fwd_b;

  assign ALUControlE = r_alucontrole;
  assign PCE         = r_pce;
  assign ImmExtE     = r_immexte;
  assign RdE         = r_rde;
  assign RegWriteE   = r_regwritee;
  assign MemWriteE   = r_memwritee;
  assign BranchE     = r_branche;
  assign JumpE       = r_jumpe;
  assign ResultSrcE  = r_resultsrce;

  assign StallF      = w_load_use;
  assign StallD      = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  // Output field selectors used by the scoreboard
  localparam int FSrcA  = 0;
  localparam int FSrcB  = 1;
  localparam int FWd    = 2;
  localparam int FRegW  = 3;
  localparam int FMemW  = 4;
  localparam int FRd    = 5;
  localparam int FStF   = 6;
  localparam int FStD   = 7;
  localparam int FAluC  = 8;
  localparam int FPc    = 9;
  localparam int FImm   = 10;
  localparam int FRes   = 11;
  localparam int FBr    = 12;
  localparam int FJmp   = 13;

  typedef struct {
    int          due;
    int          fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  logic [DW-1:0] RD1D, RD2D, PCD, ImmExtD;
  logic [RW-1:0] Rs1D, Rs2D, RdD;
  logic [3:0]    ALUControlD;
  logic          ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]    ResultSrcD;
  logic          FlushE;
  logic [DW-1:0] ALUResultM, ResultW;
  logic [RW-1:0] RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [DW-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [3:0]    ALUControlE;
  logic [RW-1:0] RdE;
  logic          RegWriteE, MemWriteE, BranchE, JumpE;
  logic [1:0]    ResultSrcE;
  logic          StallF, StallD;

  ex_operand_stage #(.D_WIDTH(DW), .R_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUControlD(ALUControlD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ResultSrcD(ResultSrcD), .FlushE(FlushE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .PCE(PCE), .ImmExtE(ImmExtE), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .StallF(StallF), .StallD(StallD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] get_act(input int fld);
    case (fld)
      FSrcA:   return SrcAE;
      FSrcB:   return SrcBE;
      FWd:     return WriteDataE;
      FRegW:   return {31'd0, RegWriteE};
      FMemW:   return {31'd0, MemWriteE};
      FRd:     return {27'd0, RdE};
      FStF:    return {31'd0, StallF};
      FStD:    return {31'd0, StallD};
      FAluC:   return {28'd0, ALUControlE};
      FPc:     return PCE;
      FImm:    return ImmExtE;
      FRes:    return {30'd0, ResultSrcE};
      FBr:     return {31'd0, BranchE};
      FJmp:    return {31'd0, JumpE};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = get_act(e.fld);
      n_checks++;
      if (e.due != cyc) begin
        n_errors++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
      end else if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic expect_at(input int due, input int fld, input logic [31:0] v,
                           input string name);
    exp_t e;
    e.due = due;
    e.fld = fld;
    e.exp = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; ALUControlD = '0;
    ALUSrcAD = 1'b0; ALUSrcBD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0;
    BranchD = 1'b0; JumpD = 1'b0; ResultSrcD = '0; FlushE = 1'b0;
  endtask

  task automatic clear_mw();
    ALUResultM = '0; ResultW = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_d();
    clear_mw();
    repeat (2) tick();

    // 1. Load a fully nonzero instruction, then assert reset mid-cycle.
    rst = 1'b0;
    RD1D = 32'h11; RD2D = 32'h22; PCD = 32'h40; ImmExtD = 32'h4;
    Rs1D = 5'd7; Rs2D = 5'd8; RdD = 5'd9; ALUControlD = 4'd5;
    RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1; ResultSrcD = 2'b10;
    tick();
    #1 rst = 1'b1;
    expect_at(cyc, FRegW, 0, "rst_regwrite");
    expect_at(cyc, FMemW, 0, "rst_memwrite");
    expect_at(cyc, FBr,   0, "rst_branch");
    expect_at(cyc, FJmp,  0, "rst_jump");
    expect_at(cyc, FRd,   0, "rst_rd");
    expect_at(cyc, FAluC, 0, "rst_aluctl");
    expect_at(cyc, FRes,  0, "rst_resultsrc");
    expect_at(cyc, FPc,   0, "rst_pc");
    expect_at(cyc, FSrcA, 0, "rst_srca");
    expect_at(cyc, FSrcB, 0, "rst_srcb");
    expect_at(cyc, FWd,   0, "rst_wdata");
    expect_at(cyc, FStF,  0, "rst_stallf");
    expect_at(cyc, FStD,  0, "rst_stalld");
    tick();
    rst = 1'b0;
    // add x3, x1, x2
    clear_d();
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; RD1D = 32'd5; RD2D = 32'd7; RegWriteD = 1'b1;
    expect_at(cyc + 1, FSrcA, 5, "add_srca");
    expect_at(cyc + 1, FSrcB, 7, "add_srcb");
    expect_at(cyc + 1, FRegW, 1, "add_regwrite");
    expect_at(cyc + 1, FRd,   3, "add_rd");
    expect_at(cyc + 1, FMemW, 0, "add_memwrite");
    tick();

    // 2. Forwarding priority on operand A (Rs1E = 4, RD1E = 0x33).
    clear_d();
    Rs1D = 5'd4; RdD = 5'd10; RD1D = 32'h33; RegWriteD = 1'b1;
    tick();
    RdM = 5'd4; RegWriteM = 1'b1; ALUResultM = 32'hAA;
    RdW = 5'd4; RegWriteW = 1'b1; ResultW = 32'hBB;
    expect_at(cyc, FSrcA, 32'hAA, "fwd_m_over_w");
    tick();
    RegWriteM = 1'b0;
    expect_at(cyc, FSrcA, 32'hBB, "fwd_w_only");
    tick();
    RegWriteW = 1'b0;
    expect_at(cyc, FSrcA, 32'h33, "fwd_none");
    tick();

    // 3. Register x0 is never forwarded.
    clear_d();
    clear_mw();
    RD2D = 32'h12;
    tick();
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hFF;
    RdW = 5'd0; RegWriteW = 1'b1; ResultW = 32'hEE;
    expect_at(cyc, FSrcB, 32'h12, "x0_srcb");
    expect_at(cyc, FWd,   32'h12, "x0_wdata");
    expect_at(cyc, FSrcA, 32'h0,  "x0_srca");
    tick();

    // 4. Load-use: lw x5 in E, add x6, x5, x1 in D.
    clear_mw();
    clear_d();
    RdD = 5'd5; ResultSrcD = 2'b01; RegWriteD = 1'b1; Rs1D = 5'd2; RD1D = 32'h100;
    ImmExtD = 32'h4; ALUSrcBD = 1'b1;
    tick();
    clear_d();
    Rs1D = 5'd5; Rs2D = 5'd1; RdD = 5'd6; RD1D = 32'hDEAD; RD2D = 32'h3; RegWriteD = 1'b1;
    expect_at(cyc, FStF, 1, "lu_stallf");
    expect_at(cyc, FStD, 1, "lu_stalld");
    expect_at(cyc, FRes, 1, "lu_lw_resultsrc");
    expect_at(cyc, FRd,  5, "lu_lw_rd");
    expect_at(cyc + 1, FRegW, 0, "lu_bubble_regwrite");
    expect_at(cyc + 1, FRd,   0, "lu_bubble_rd");
    expect_at(cyc + 1, FStF,  0, "lu_stall_released");
    expect_at(cyc + 1, FStD,  0, "lu_stalld_released");
    tick();
    tick();
    // lw has reached W; the held add is now in E.
    RdW = 5'd5; RegWriteW = 1'b1; ResultW = 32'h77;
    expect_at(cyc, FSrcA, 32'h77, "lu_fwd_from_w");
    expect_at(cyc, FSrcB, 32'h3,  "lu_add_srcb");
    expect_at(cyc, FRd,   6,      "lu_add_rd");
    expect_at(cyc, FRegW, 1,      "lu_add_regwrite");
    expect_at(cyc, FStF,  0,      "lu_no_restall");
    tick();

    // 5. Flush squashes a store entering E; next cycle it is accepted.
    clear_mw();
    clear_d();
    MemWriteD = 1'b1; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd8; RD1D = 32'h50; RD2D = 32'h60;
    ImmExtD = 32'h8; ALUSrcBD = 1'b1; BranchD = 1'b1; FlushE = 1'b1;
    expect_at(cyc + 1, FMemW, 0, "flush_memwrite");
    expect_at(cyc + 1, FRegW, 0, "flush_regwrite");
    expect_at(cyc + 1, FRd,   0, "flush_rd");
    expect_at(cyc + 1, FBr,   0, "flush_branch");
    expect_at(cyc + 1, FSrcB, 0, "flush_srcb");
    tick();
    FlushE = 1'b0;
    expect_at(cyc + 1, FMemW, 1,      "noflush_memwrite");
    expect_at(cyc + 1, FSrcB, 32'h8,  "noflush_srcb_imm");
    expect_at(cyc + 1, FWd,   32'h60, "noflush_wdata");
    tick();

    // 6. PC/immediate select, with rs2 still forwarded onto WriteDataE.
    clear_d();
    ALUSrcAD = 1'b1; ALUSrcBD = 1'b1; PCD = 32'h100; ImmExtD = 32'h20;
    Rs1D = 5'd1; Rs2D = 5'd9; RD1D = 32'h1; RD2D = 32'h2; RdD = 5'd4; RegWriteD = 1'b1;
    ALUControlD = 4'h3; BranchD = 1'b1; JumpD = 1'b1; ResultSrcD = 2'b10;
    tick();
    RdM = 5'd9; RegWriteM = 1'b1; ALUResultM = 32'h9;
    expect_at(cyc, FSrcA, 32'h100, "sel_srca_pc");
    expect_at(cyc, FSrcB, 32'h20,  "sel_srcb_imm");
    expect_at(cyc, FWd,   32'h9,   "sel_wdata_fwd");
    expect_at(cyc, FAluC, 3,       "sel_aluctl");
    expect_at(cyc, FPc,   32'h100, "sel_pce");
    expect_at(cyc, FImm,  32'h20,  "sel_imme");
    expect_at(cyc, FBr,   1,       "sel_branch");
    expect_at(cyc, FJmp,  1,       "sel_jump");
    expect_at(cyc, FRes,  2,       "sel_resultsrc");
    tick();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and execute-stage operand front end for the pipelined RV32I core; it sits directly upstream of the ALU.
- Registers decode-stage operands and control into E.
- Resolves EX/MEM and MEM/WB forwarding and applies the ALUSrc muxes to drive ALU SrcA/SrcB/ALUControl.
- Detects load-use hazards, stalls fetch/decode and inserts a bubble.

Parameters:
D_WIDTH, 32, datapath width (operands, PC, immediate, results)
R_WIDTH, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
RD1D, RD2D  in  D_WIDTH  register-file read data from decode
PCD, ImmExtD  in  D_WIDTH  decode PC and extended immediate
Rs1D, Rs2D, RdD  in  R_WIDTH  decode register indices
ALUControlD  in  4  ALU operation code
ALUSrcAD  in  1  1: SrcA = PC; 0: forwarded rs1
ALUSrcBD  in  1  1: SrcB = immediate; 0: forwarded rs2
RegWriteD, MemWriteD, BranchD, JumpD  in  1  decode control
ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
FlushE  in  1  branch/jump taken; squash instruction entering E
ALUResultM, ResultW  in  D_WIDTH  forwarding sources
RdM, RdW  in  R_WIDTH  destination indices in M and W
RegWriteM, RegWriteW  in  1  write enables in M and W
SrcAE, SrcBE  out  D_WIDTH  ALU operands
ALUControlE  out  4  registered ALU op
WriteDataE  out  D_WIDTH  forwarded rs2 for stores
PCE, ImmExtE  out  D_WIDTH  registered PC and immediate (branch target)
RdE  out  R_WIDTH  registered destination
RegWriteE, MemWriteE, BranchE, JumpE  out  1  registered control
ResultSrcE  out  2  registered result select
StallF, StallD  out  1  hold PC and IF/ID register

Behaviour:
- One clock, clk. rst is asynchronous and active-high; while asserted, every E register clears to 0. This gives a bubble: RegWriteE=MemWriteE=BranchE=JumpE=0, RdE=0, ALUControlE=0, ResultSrcE=00.
- After reset, outputs follow the combinational rules below from the zeroed registers: SrcAE=SrcBE=WriteDataE=0 unless a forward matches, and StallF=StallD=0.
- Latency: D inputs appear on E outputs one clock after capture.
- Capture rule at each rising edge:
  - FlushE=1 or LoadUse=1: load the bubble (all fields 0).
  - Otherwise: load all D inputs, including Rs1D/Rs2D into internal Rs1E/Rs2E.
  - FlushE and LoadUse both asserted: still a bubble. No other priority is needed.
- LoadUse (combinational) = (ResultSrcE==01) & RegWriteE & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - StallF = StallD = LoadUse.
  - Stall lasts exactly one cycle: the bubble makes ResultSrcE 00 on the next cycle.
- Forwarding, operand A (combinational):
  - RegWriteM & RdM!=0 & RdM==Rs1E -> ALUResultM;
  - else RegWriteW & RdW!=0 & RdW==Rs1E -> ResultW;
  - else RD1E.
  - M has priority over W. x0 is never forwarded.
- Forwarding, operand B: same rule using Rs2E and RD2E, giving fwdB.
- Operand muxes: SrcAE = ALUSrcAE ? PCE : fwdA. SrcBE = ALUSrcBE ? ImmExtE : fwdB. WriteDataE = fwdB regardless of ALUSrcBE.
- ALUSrcA/ALUSrcB selects: registered alongside other control; cleared by bubble.
- Bubble outputs: must never write the register file or memory. Bubble Rs1E/Rs2E = 0, so no spurious forwards.
- Reset mid-operation: asserting rst asynchronously clears E regardless of clk, and all in-flight E state is lost. Deassertion needs no special sequencing.
- Index compares are full R_WIDTH equality. No data arithmetic in this block.

Test Plan:
1. Reset: assert rst mid-cycle with nonzero D inputs -> all E outputs immediately 0, StallF=StallD=0. Release, apply add x3,x1,x2 with RD1D=5, RD2D=7 -> next cycle SrcAE=5, SrcBE=7, RegWriteE=1, RdE=3.
2. Forward priority:
   - Setup: Rs1E=4, RdM=4/RegWriteM=1/ALUResultM=0xAA, RdW=4/RegWriteW=1/ResultW=0xBB -> SrcAE=0xAA.
   - Drop RegWriteM -> SrcAE=0xBB.
   - Drop both -> SrcAE=RD1E.
3. x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0x12 -> SrcBE=WriteDataE=0x12.
4. Load-use: lw x5 in E (ResultSrcE=01, RdE=5), add x6,x5,x1 in D.
   - Cycle 1: StallF=StallD=1.
   - Next edge: E is a bubble (RegWriteE=0), StallF=0, add held in D.
   - Following edge: add captured; x5 forwarded from ResultW.
5. Flush: FlushE=1 with valid sw in D (MemWriteD=1) -> next cycle MemWriteE=0, RegWriteE=0, RdE=0.
6. Immediate/PC select: ALUSrcAD=1, ALUSrcBD=1, PCD=0x100, ImmExtD=0x20, matching M forward on rs2 with ALUResultM=0x9 -> SrcAE=0x100, SrcBE=0x20, WriteDataE=0x9.
